ram_req_ctrl: RTL and testbench

//  Request/response front-end for the single-port synchronous `ram` block (PortA).
//  - Accepts one read or byte-masked write at a time over valid/ready.
//  - Drives the RAM port and returns read data or write completion over a valid/ready response channel.
//  - The RAM has no byte enables, so partial writes run as an internal read-modify-write.

---
 rtl/ram_req_ctrl.sv | 136 +++++++++++++
 tb/tb_ram_req_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready request/response front-end for a single-port
// synchronous RAM. Handles one transaction at a time. The RAM has no byte
// enables, so a partially masked write is done as a read-modify-write.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; RAM port driven directly from request
// RD    | read issued at accept edge; capture RamDataOut this cycle
// MERGE | partial write: merge old word with masked write data, write
// RSP   | response presented; held stable until RspReady
module ram_req_ctrl #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [ADDRWIDTH-1:0]   ReqAddr,
  input  logic [DATAWIDTH-1:0]   ReqWData,
  input  logic [DATAWIDTH/8-1:0] ReqByteEn,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic                   RspIsWrite,
  output logic [DATAWIDTH-1:0]   RspRData,
  output logic [ADDRWIDTH-1:0]   RamAddr,
  output logic [DATAWIDTH-1:0]   RamDataIn,
  output logic                   RamWriteEnable,
  input  logic [DATAWIDTH-1:0]   RamDataOut
);

  localparam int BEWIDTH = DATAWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2,
    RSP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [BEWIDTH-1:0]   be_q, be_d;
  logic                 rsp_is_write_q, rsp_is_write_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 accept;

  assign ReqReady   = (state_q == IDLE) & RstN;
  assign accept     = ReqValid & ReqReady;
  assign RspValid   = (state_q == RSP);
  assign RspIsWrite = rsp_is_write_q;
  assign RspRData   = rsp_rdata_q;

  // State and transaction registers; synchronous active-low reset drops any
  // in-flight transaction or pending response.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      rsp_is_write_q <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  // Next-state, latched request fields, response payload and RAM port drive.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    rsp_is_write_d = rsp_is_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    RamAddr        = addr_q;
    RamDataIn      = wdata_q;
    RamWriteEnable = 1'b0;

    unique case (state_q)
      IDLE: begin
        // With no valid request the RAM just performs a harmless read.
        RamAddr        = ReqAddr;
        RamDataIn      = ReqWData;
        RamWriteEnable = ReqValid & ReqWrite & (&ReqByteEn) & RstN;
        if (accept) begin
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          be_d    = ReqByteEn;
          if (!ReqWrite) begin
            state_d = RD;
          end else if ((&ReqByteEn) || (ReqByteEn == '0)) begin
            // Full write already committed this edge; empty mask writes nothing.
            state_d        = RSP;
            rsp_is_write_d = 1'b1;
            rsp_rdata_d    = '0;
          end else begin
            state_d = MERGE;
          end
        end
      end
      RD: begin
        rsp_is_write_d = 1'b0;
        rsp_rdata_d    = RamDataOut;
        state_d        = RSP;
      end
      MERGE: begin
        // Old word was read at the accept edge and is on RamDataOut now.
        RamWriteEnable = RstN;
        for (int i = 0; i < BEWIDTH; i++) begin
          RamDataIn[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : RamDataOut[8*i +: 8];
        end
        rsp_is_write_d = 1'b1;
        rsp_rdata_d    = '0;
        state_d        = RSP;
      end
      RSP: begin
        if (RspReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl with a behavioural synchronous single-port RAM.
module tb_ram_req_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BW = DW / 8;

  logic          Clk = 1'b0;
  logic          RstN;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReqWData;
  logic [BW-1:0] ReqByteEn;
  logic          RspValid;
  logic          RspReady;
  logic          RspIsWrite;
  logic [DW-1:0] RspRData;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataIn;
  logic          RamWriteEnable;
  logic [DW-1:0] RamDataOut;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 Clk = ~Clk;

  ram_req_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk(Clk), .RstN(RstN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqByteEn(ReqByteEn),
    .RspValid(RspValid), .RspReady(RspReady), .RspIsWrite(RspIsWrite),
    .RspRData(RspRData), .RamAddr(RamAddr), .RamDataIn(RamDataIn),
    .RamWriteEnable(RamWriteEnable), .RamDataOut(RamDataOut)
  );

  // Read-first synchronous RAM with a write counter.
  always @(posedge Clk) begin
    RamDataOut <= mem[RamAddr];
    if (RamWriteEnable) begin
      mem[RamAddr] <= RamDataIn;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_wr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int lat;
    bit got;
    int wr_start;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge Clk);
    ReqValid  = 1'b1;
    ReqWrite  = v.wr;
    ReqAddr   = v.addr;
    ReqWData  = v.wdata;
    ReqByteEn = v.be;
    RspReady  = 1'b1;
    wr_start  = wr_cnt;
    #1;
    check({tag, "_req_ready"}, ReqReady, 1);
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 10) begin
      @(negedge Clk);
      lat++;
      if (RspValid) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: no RspValid within %0d cycles", tag, lat);
    end else begin
      check({tag, "_latency"}, lat, v.exp_lat);
      check({tag, "_is_write"}, RspIsWrite, v.wr);
      check({tag, "_rdata"}, RspRData, v.exp_rdata);
    end
    @(posedge Clk);
    #1;
    check({tag, "_ram_writes"}, wr_cnt - wr_start, v.exp_wr);
  endtask

  initial begin
    logic [DW-1:0] hold_data;
    int wr_start;
    bit got;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    //          wr    addr      wdata         be       exp_rdata     lat we
    vecs[0]  = '{1'b1, 16'h0010, 32'hAABBCCDD, 4'hF,    32'h0,        1, 1};
    vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0,    32'hAABBCCDD, 2, 0};
    vecs[2]  = '{1'b1, 16'h0010, 32'h11223344, 4'b0101, 32'h0,        2, 1};
    vecs[3]  = '{1'b0, 16'h0010, 32'h0,        4'h0,    32'hAA22CC44, 2, 0};
    vecs[4]  = '{1'b1, 16'h0020, 32'h12345678, 4'hF,    32'h0,        1, 1};
    vecs[5]  = '{1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0,    32'h0,        1, 0};
    vecs[6]  = '{1'b0, 16'h0020, 32'h0,        4'hF,    32'h12345678, 2, 0};
    vecs[7]  = '{1'b1, 16'h0000, 32'h0000A5A5, 4'hF,    32'h0,        1, 1};
    vecs[8]  = '{1'b1, 16'hFFFF, 32'h5A5A0000, 4'hF,    32'h0,        1, 1};
    vecs[9]  = '{1'b0, 16'h0000, 32'h0,        4'h0,    32'h0000A5A5, 2, 0};
    vecs[10] = '{1'b0, 16'hFFFF, 32'h0,        4'h0,    32'h5A5A0000, 2, 0};
    vecs[11] = '{1'b1, 16'hFFFF, 32'hDEADBEEF, 4'b1000, 32'h0,        2, 1};
    vecs[12] = '{1'b0, 16'hFFFF, 32'h0,        4'h0,    32'hDE5A0000, 2, 0};
    vecs[13] = '{1'b0, 16'h0000, 32'h0,        4'h0,    32'h0000A5A5, 2, 0};

    // Reset with a full write presented: nothing may reach the RAM.
    RstN      = 1'b0;
    ReqValid  = 1'b1;
    ReqWrite  = 1'b1;
    ReqAddr   = 16'h0040;
    ReqWData  = 32'hCAFEF00D;
    ReqByteEn = 4'hF;
    RspReady  = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_req_ready", ReqReady, 0);
    check("rst_we", RamWriteEnable, 0);
    check("rst_rsp_valid", RspValid, 0);
    check("rst_rsp_is_write", RspIsWrite, 0);
    check("rst_rsp_rdata", RspRData, 0);
    check("rst_mem_untouched", mem[16'h0040], 0);
    ReqValid = 1'b0;
    RstN     = 1'b1;

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Read with response back-pressure for 5 cycles.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'h0010; ReqByteEn = 4'h0;
    RspReady = 1'b0;
    @(posedge Clk);
    #1;
    ReqWrite = 1'b1; ReqAddr = 16'h0050; ReqWData = 32'h77777777; ReqByteEn = 4'hF;
    wr_start = wr_cnt;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clk);
      if (RspValid) got = 1;
    end
    check("bp_rsp_valid_seen", got, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("bp_hold%0d_valid", i), RspValid, 1);
      check($sformatf("bp_hold%0d_rdata", i), RspRData, 32'hAA22CC44);
      check($sformatf("bp_hold%0d_req_ready", i), ReqReady, 0);
      check($sformatf("bp_hold%0d_we", i), RamWriteEnable, 0);
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    check("bp_after_valid", RspValid, 0);
    check("bp_after_req_ready", ReqReady, 1);
    check("bp_no_writes", wr_cnt - wr_start, 0);
    check("bp_mem_0050", mem[16'h0050], 0);

    // Reset during MERGE of a partial write aborts the write.
    run_txn('{1'b1, 16'h0030, 32'h12345678, 4'hF, 32'h0, 1, 1}, 100);
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h0030;
    ReqWData = 32'hFFFFFFFF; ReqByteEn = 4'b0011;
    RspReady = 1'b1;
    wr_start = wr_cnt;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    @(negedge Clk);
    check("mrg_we_before_rst", RamWriteEnable, 1);
    RstN = 1'b0;
    #1;
    check("mrg_we_in_rst", RamWriteEnable, 0);
    check("mrg_req_ready_in_rst", ReqReady, 0);
    @(negedge Clk);
    check("mrg_rsp_valid_after_rst", RspValid, 0);
    check("mrg_no_write", wr_cnt - wr_start, 0);
    RstN = 1'b1;
    @(negedge Clk);
    check("mrg_rsp_valid_idle", RspValid, 0);
    hold_data = mem[16'h0030];
    check("mrg_mem_unchanged", hold_data, 32'h12345678);
    run_txn('{1'b0, 16'h0030, 32'h0, 4'h0, 32'h12345678, 2, 0}, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
